// File: rtl/prom_loader.sv
// Byte-stream PROM image loader: assembles little-endian words from a byte link and writes them to memory.
// Define PROM_LOADER_CHECKSUM_EN to check an image-trailing modulo-256 checksum byte.
module prom_loader #(
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned DEPTH      = 42,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned WORD_W    = 8 * WORD_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart_i,
    input  logic              enable_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_ready_i,
    output logic              rx_ack_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              done_o,
    output logic              checksum_err_o
);

    localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RECEIVE  = 2'd0,
        S_FLUSH    = 2'd1,
        S_DONE     = 2'd2
`ifdef PROM_LOADER_CHECKSUM_EN
        , S_CHECKSUM = 2'd3
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX_W-1:0]  byte_idx_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] wr_data_next;
    logic              wr_en_next;
    logic              done_next;
    logic              ack;
    logic              last_byte;
    logic              last_addr;

`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next;
    logic       err;
    logic       err_next;

    assign checksum_err_o = err;
`else
    assign checksum_err_o = 1'b0;
`endif

    // A byte is taken whenever the link offers one, except while writing or restarting.
    assign ack       = rx_ready_i && enable_i && !restart_i && (state != S_FLUSH) && !reset;
    assign rx_ack_o  = ack;
    assign last_byte = (byte_idx == LAST_IDX);
    assign last_addr = (addr == LAST_ADDR);
    assign wr_addr_o = addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RECEIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (restart_i) begin
            state_next = S_RECEIVE;
        end else begin
            case (state)
                S_RECEIVE: begin
                    if (ack && last_byte) begin
                        state_next = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (last_addr) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                        state_next = S_CHECKSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_RECEIVE;
                    end
                end
`ifdef PROM_LOADER_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (ack) begin
                        state_next = S_DONE;
                    end
                end
`endif
                default: state_next = state;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        byte_idx_next = byte_idx;
        addr_next     = addr;
        word_next     = word;
        wr_data_next  = wr_data_o;
        wr_en_next    = 1'b0;
        done_next     = done_o;
`ifdef PROM_LOADER_CHECKSUM_EN
        csum_next     = csum;
        err_next      = err;
`endif
        if (restart_i) begin
            byte_idx_next = '0;
            addr_next     = '0;
            word_next     = '0;
            done_next     = 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
            csum_next     = 8'd0;
            err_next      = 1'b0;
`endif
        end else begin
            case (state)
                S_RECEIVE: begin
                    if (ack) begin
                        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                            if (byte_idx == IDX_W'(b)) begin
                                word_next[8*b +: 8] = rx_data_i;
                            end
                        end
`ifdef PROM_LOADER_CHECKSUM_EN
                        csum_next = csum + rx_data_i;
`endif
                        if (last_byte) begin
                            byte_idx_next = '0;
                            wr_en_next    = 1'b1;
                            wr_data_next  = word_next;
                        end else begin
                            byte_idx_next = byte_idx + IDX_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    addr_next = last_addr ? '0 : addr + ADDR_W'(1);
`ifndef PROM_LOADER_CHECKSUM_EN
                    if (last_addr) begin
                        done_next = 1'b1;
                    end
`endif
                end
`ifdef PROM_LOADER_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (ack) begin
                        csum_next = csum + rx_data_i;
                        err_next  = (csum_next != 8'd0);
                        done_next = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= '0;
            addr      <= '0;
            word      <= '0;
            wr_data_o <= '0;
            wr_en_o   <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            byte_idx  <= byte_idx_next;
            addr      <= addr_next;
            word      <= word_next;
            wr_data_o <= wr_data_next;
            wr_en_o   <= wr_en_next;
            done_o    <= done_next;
        end
    end

`ifdef PROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else begin
            csum <= csum_next;
            err  <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_prom_loader.sv
// Self-checking bench for prom_loader (DEPTH=4, WORD_BYTES=2) with a byte-count based scoreboard.
// Exercises the checksum path when PROM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_prom_loader;

    localparam int unsigned WB     = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned IMG    = WB * DEPTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              restart = 1'b0;
    logic              enable = 1'b0;
    logic              rx_ready = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ack_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [WORD_W-1:0] wr_data_o;
    logic              done_o;
    logic              checksum_err_o;

    int errors = 0;
    int checks = 0;

    // Model state: bytes consumed since restart, completed words, pending write.
    int                m_cnt = 0;
    int                m_flushes = 0;
    bit                m_flush = 1'b0;
    bit                m_cs_taken = 1'b0;
    logic [WORD_W-1:0] m_acc = '0;
    logic [WORD_W-1:0] m_word = '0;
    logic [7:0]        m_sum = 8'h00;

    always #5 clk = ~clk;

    prom_loader #(.WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .restart_i(restart),
        .enable_i(enable),
        .rx_data_i(rx_data),
        .rx_ready_i(rx_ready),
        .rx_ack_o(rx_ack_o),
        .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .done_o(done_o),
        .checksum_err_o(checksum_err_o)
    );

    // Scoreboard: predicts every cycle from the count of consumed bytes.
    always @(negedge clk) begin : scoreboard
        bit                exp_ack;
        bit                exp_done;
        bit                exp_err;
        logic [ADDR_W-1:0] exp_addr;
        int                idx;
        if (reset) begin
            m_cnt = 0; m_flushes = 0; m_flush = 0; m_cs_taken = 0;
            m_acc = '0; m_sum = 8'h00;
        end else begin
            exp_ack  = rx_ready && enable && !restart && !m_flush;
            exp_addr = ADDR_W'(m_flushes % DEPTH);
`ifdef PROM_LOADER_CHECKSUM_EN
            exp_done = m_cs_taken;
            exp_err  = m_cs_taken && (m_sum != 8'h00);
`else
            exp_done = (m_flushes == DEPTH);
            exp_err  = 1'b0;
`endif
            checks++;
            if (rx_ack_o !== exp_ack) begin
                errors++; $display("FAIL sb_ack t=%0t got=%b exp=%b", $time, rx_ack_o, exp_ack);
            end
            checks++;
            if (wr_en_o !== m_flush) begin
                errors++; $display("FAIL sb_wr_en t=%0t got=%b exp=%b", $time, wr_en_o, m_flush);
            end
            checks++;
            if (wr_addr_o !== exp_addr) begin
                errors++; $display("FAIL sb_addr t=%0t got=%0d exp=%0d", $time, wr_addr_o, exp_addr);
            end
            if (m_flush) begin
                checks++;
                if (wr_data_o !== m_word) begin
                    errors++; $display("FAIL sb_data t=%0t got=%h exp=%h", $time, wr_data_o, m_word);
                end
            end
            checks++;
            if (done_o !== exp_done) begin
                errors++; $display("FAIL sb_done t=%0t got=%b exp=%b", $time, done_o, exp_done);
            end
            checks++;
            if (checksum_err_o !== exp_err) begin
                errors++; $display("FAIL sb_cs_err t=%0t got=%b exp=%b", $time, checksum_err_o, exp_err);
            end
            if (restart) begin
                m_cnt = 0; m_flushes = 0; m_flush = 0; m_cs_taken = 0;
                m_acc = '0; m_sum = 8'h00;
            end else begin
                if (m_flush) m_flushes++;
                m_flush = 1'b0;
                if (exp_ack) begin
                    if (m_cnt < IMG) begin
                        idx   = m_cnt % WB;
                        m_acc = m_acc | (WORD_W'(rx_data) << (8 * idx));
                        m_sum = m_sum + rx_data;
                        m_cnt++;
                        if (m_cnt % WB == 0) begin
                            m_flush = 1'b1; m_word = m_acc; m_acc = '0;
                        end
                    end
`ifdef PROM_LOADER_CHECKSUM_EN
                    else if (!m_cs_taken) begin
                        m_sum = m_sum + rx_data;
                        m_cs_taken = 1'b1;
                    end
`endif
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        rx_ready = 1'b1; rx_data = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rx_ack_o;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h got no ack, required ack within 20 cycles", b);
        end
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rx_ready = 1'b1; enable = 1'b1; rx_data = 8'h5A;
        repeat (2) @(negedge clk);
        checks++; if (rx_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", rx_ack_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (checksum_err_o !== 1'b0) begin errors++; $display("FAIL reset_cs_err got=%b exp=0", checksum_err_o); end
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", wr_addr_o); end
        @(posedge clk); #1;
        reset = 1'b0; rx_ready = 1'b0;
    endtask

    task automatic test_first_word();
        send_byte(8'h34);
        send_byte(8'h12);
        @(negedge clk);
        checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL first_wr_en got=%b exp=1", wr_en_o); end
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL first_addr got=%0d exp=0", wr_addr_o); end
        checks++; if (wr_data_o !== 16'h1234) begin errors++; $display("FAIL first_data got=%h exp=1234", wr_data_o); end
    endtask

    task automatic test_restart();
        send_byte(8'hAA);
        @(posedge clk); #1;
        restart = 1'b1; rx_ready = 1'b1; rx_data = 8'hBB;
        @(negedge clk);
        checks++; if (rx_ack_o !== 1'b0) begin errors++; $display("FAIL restart_ack got=%b exp=0", rx_ack_o); end
        @(posedge clk); #1;
        restart = 1'b0; rx_ready = 1'b0;
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL restart_wr_en got=%b exp=1", wr_en_o); end
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL restart_addr got=%0d exp=0", wr_addr_o); end
        checks++; if (wr_data_o !== 16'h6655) begin errors++; $display("FAIL restart_data got=%h exp=6655", wr_data_o); end
    endtask

    task automatic test_enable_stall();
        send_byte(8'h34);
        enable = 1'b0; rx_ready = 1'b1; rx_data = 8'h12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rx_ack_o !== 1'b0) begin errors++; $display("FAIL stall_ack cyc=%0d got=%b exp=0", i, rx_ack_o); end
            checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL stall_wr_en cyc=%0d got=%b exp=0", i, wr_en_o); end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (rx_ack_o !== 1'b1) begin errors++; $display("FAIL stall_resume_ack got=%b exp=1", rx_ack_o); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL stall_wr_en_after got=%b exp=1", wr_en_o); end
        checks++; if (wr_addr_o !== 2'd1) begin errors++; $display("FAIL stall_addr got=%0d exp=1", wr_addr_o); end
        checks++; if (wr_data_o !== 16'h1234) begin errors++; $display("FAIL stall_data got=%h exp=1234", wr_data_o); end
    endtask

    task automatic test_full_image();
        logic [7:0]        b;
        logic [WORD_W-1:0] exp_w;
        pulse_restart();
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_byte(b);
            if (i % 2 == 0) begin
                exp_w = {8'(i), 8'(i - 1)};
                @(negedge clk);
                checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL image_wr_en word=%0d got=%b exp=1", i/2 - 1, wr_en_o); end
                checks++; if (wr_addr_o !== ADDR_W'(i/2 - 1)) begin errors++; $display("FAIL image_addr got=%0d exp=%0d", wr_addr_o, i/2 - 1); end
                checks++; if (wr_data_o !== exp_w) begin errors++; $display("FAIL image_data got=%h exp=%h", wr_data_o, exp_w); end
            end
        end
        @(negedge clk);
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL image_addr_wrap got=%0d exp=0", wr_addr_o); end
`ifdef PROM_LOADER_CHECKSUM_EN
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL image_done_early got=%b exp=0", done_o); end
        send_byte(8'hDC);
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL cs_good_done got=%b exp=1", done_o); end
        checks++; if (checksum_err_o !== 1'b0) begin errors++; $display("FAIL cs_good_err got=%b exp=0", checksum_err_o); end
        pulse_restart();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'hDD);
        @(negedge clk);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL cs_bad_done got=%b exp=1", done_o); end
        checks++; if (checksum_err_o !== 1'b1) begin errors++; $display("FAIL cs_bad_err got=%b exp=1", checksum_err_o); end
`else
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL image_done got=%b exp=1", done_o); end
`endif
        send_byte(8'h99);
        @(negedge clk);
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL done_discard_wr got=%b exp=0", wr_en_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", done_o); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] sum;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rx_ready = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 4) != 0);
            restart  = ($urandom_range(0, 29) == 0);
            rx_data  = 8'($urandom);
        end
        @(posedge clk); #1;
        rx_ready = 1'b0; enable = 1'b1; restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        sum = 8'h00;
        for (int i = 0; i < int'(IMG); i++) begin
            b = 8'($urandom);
            sum = sum + b;
            send_byte(b);
        end
`ifdef PROM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
        @(negedge clk);
`else
        repeat (2) @(negedge clk);
`endif
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rand_done got=%b exp=1", done_o); end
        checks++; if (checksum_err_o !== 1'b0) begin errors++; $display("FAIL rand_cs_err got=%b exp=0", checksum_err_o); end
    endtask

    task automatic test_reset_flush();
        pulse_restart();
        send_byte(8'h11);
        send_byte(8'h22);
        rx_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_flush_wr_en got=%b exp=0", wr_en_o); end
        checks++; if (rx_ack_o !== 1'b0) begin errors++; $display("FAIL rst_flush_ack got=%b exp=0", rx_ack_o); end
        @(posedge clk); #1;
        reset = 1'b0; rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_flush_no_wr cyc=%0d got=%b exp=0", i, wr_en_o); end
            checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL rst_flush_addr cyc=%0d got=%0d exp=0", i, wr_addr_o); end
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_restart();
        test_enable_stall();
        test_full_image();
        test_random();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
